// File: rtl/spi_rx_regs.sv
// spi_rx_regs: write-only SPI Mode 0 slave feeding the oscillator control register bank.
// All logic runs on clk; SCK, CS and MOSI are brought in through 2-flop synchronizers.
// Frame format: [address byte][data byte]... while CS is low.
// Optional feature macro SPI_RX_BURST_EN: when defined, every data byte in a frame is
// written with address auto-increment; when undefined, only the first data byte is written.
module spi_rx_regs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_mosi,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       status_gate_active,
  input  logic       status_osc_running,
  output logic [7:0] reg_control,
  output logic [7:0] reg_freq_low,
  output logic [7:0] reg_freq_mid,
  output logic [7:0] reg_freq_high,
  output logic [7:0] reg_duty,
  output logic [7:0] reg_volume,
  output logic [7:0] reg_status
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] ADDR_CONTROL   = 8'h00;
  localparam logic [7:0] ADDR_FREQ_LOW  = 8'h02;
  localparam logic [7:0] ADDR_FREQ_MID  = 8'h03;
  localparam logic [7:0] ADDR_FREQ_HIGH = 8'h04;
  localparam logic [7:0] ADDR_DUTY      = 8'h05;
  localparam logic [7:0] ADDR_VOLUME    = 8'h06;

  logic       r_sck_s1, r_sck_s2, r_sck_prev;
  logic       r_cs_s1, r_cs_s2;
  logic       r_mosi_s1, r_mosi_s2;
  logic [1:0] r_sync_valid;
  logic       r_cs_armed;
  logic [1:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_addr;

  logic       w_sck_rise;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_wr_allow;
  logic       w_wr_en;

  // Synchronize the SPI pins into clk and keep the previous SCK sample for edge detect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_sck_s1     <= 1'b0;
      r_sck_s2     <= 1'b0;
      r_sck_prev   <= 1'b0;
      r_cs_s1      <= 1'b1;
      r_cs_s2      <= 1'b1;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_sync_valid <= 2'b00;
    end else begin
      r_sck_s1     <= spi_sck;
      r_sck_s2     <= r_sck_s1;
      r_sck_prev   <= r_sck_s2;
      r_cs_s1      <= spi_cs;
      r_cs_s2      <= r_cs_s1;
      r_mosi_s1    <= spi_mosi;
      r_mosi_s2    <= r_mosi_s1;
      r_sync_valid <= {r_sync_valid[0], 1'b1};
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_prev;
  assign w_byte      = {r_shift, r_mosi_s2};
  // A CS-high sample in the same cycle as the 8th edge discards the byte.
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7) && !r_cs_s2;

`ifdef SPI_RX_BURST_EN
  assign w_wr_allow = 1'b1;
`else
  logic r_data_seen;

  // Remember that this frame already delivered its single data byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_seen <= 1'b0;
    end else if (r_cs_s2) begin
      r_data_seen <= 1'b0;
    end else if ((r_state == ST_DATA) && w_byte_done) begin
      r_data_seen <= 1'b1;
    end
  end

  assign w_wr_allow = ~r_data_seen;
`endif

  assign w_wr_en = (r_state == ST_DATA) && w_byte_done && w_wr_allow;

  // Transaction FSM: collect the address byte, then data bytes with address increment.
  // CS only opens a frame after a genuine high has been seen following reset, so a
  // reset in the middle of a frame cannot resume on the still-low CS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 7'd0;
      r_addr     <= 8'd0;
      r_cs_armed <= 1'b0;
    end else begin
      if (r_sync_valid[1] && r_cs_s2) begin
        r_cs_armed <= 1'b1;
      end
      if (r_cs_s2) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_shift   <= 7'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_cs_armed) begin
              r_state   <= ST_ADDR;
              r_bit_cnt <= 3'd0;
            end
          end
          ST_ADDR, ST_DATA: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {r_shift[5:0], r_mosi_s2};
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ST_ADDR) begin
                  r_addr  <= w_byte;
                  r_state <= ST_DATA;
                end else begin
                  r_addr  <= r_addr + 8'd1;
                end
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Register bank writes; unmapped addresses fall through with no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_control   <= 8'h00;
      reg_freq_low  <= 8'h00;
      reg_freq_mid  <= 8'h00;
      reg_freq_high <= 8'h00;
      reg_duty      <= 8'h00;
      reg_volume    <= 8'h00;
    end else if (w_wr_en) begin
      case (r_addr)
        ADDR_CONTROL:   reg_control   <= w_byte;
        ADDR_FREQ_LOW:  reg_freq_low  <= w_byte;
        ADDR_FREQ_MID:  reg_freq_mid  <= w_byte;
        ADDR_FREQ_HIGH: reg_freq_high <= w_byte;
        ADDR_DUTY:      reg_duty      <= w_byte;
        ADDR_VOLUME:    reg_volume    <= w_byte;
        default: ;
      endcase
    end
  end

  // Status register: one flop stage refreshed every clk from the core's live status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_status <= 8'h00;
    end else begin
      reg_status <= {6'b0, status_osc_running, status_gate_active};
    end
  end

endmodule

// File: tb/tb_spi_rx_regs.sv
// Self-checking bench for spi_rx_regs: directed SPI frames, a register model and a
// queue of expected register values that is drained after each frame.
module tb_spi_rx_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       status_gate_active = 1'b0;
  logic       status_osc_running = 1'b0;
  logic [7:0] reg_control, reg_freq_low, reg_freq_mid, reg_freq_high;
  logic [7:0] reg_duty, reg_volume, reg_status;

  spi_rx_regs dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .spi_mosi           (spi_mosi),
    .spi_sck            (spi_sck),
    .spi_cs             (spi_cs),
    .status_gate_active (status_gate_active),
    .status_osc_running (status_osc_running),
    .reg_control        (reg_control),
    .reg_freq_low       (reg_freq_low),
    .reg_freq_mid       (reg_freq_mid),
    .reg_freq_high      (reg_freq_high),
    .reg_duty           (reg_duty),
    .reg_volume         (reg_volume),
    .reg_status         (reg_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_regs [0:6];
  logic [7:0] m_status;
  int         n_assert = 0;
  int         n_fail = 0;
  int         sck_half = 80;

`ifdef SPI_RX_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] get_reg(input int a);
    case (a)
      0: return reg_control;
      2: return reg_freq_low;
      3: return reg_freq_mid;
      4: return reg_freq_high;
      5: return reg_duty;
      6: return reg_volume;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic bit is_writable(input int a);
    return (a == 0) || (a >= 2 && a <= 6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_regs[i] = 8'h00;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 7; i++) begin
      if (is_writable(i)) check($sformatf("%s_reg%0d", tag, i), {24'h0, get_reg(i)}, {24'h0, m_regs[i]});
    end
    check($sformatf("%s_status", tag), {24'h0, reg_status}, {24'h0, m_status});
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      #(sck_half);
      spi_sck = 1'b1;
      #(sck_half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(posedge clk);
    #2;
    spi_cs = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic cs_high();
    #(sck_half);
    spi_cs = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  // Pop every queued expectation and compare it once the frame has settled.
  task automatic drain(input string tag);
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_q%0d", tag, e.addr), {24'h0, get_reg(e.addr)}, {24'h0, e.val});
    end
    compare_all(tag);
  endtask

  // Send n bytes (MSB-first from payload) in one CS frame, updating model and queue.
  task automatic send_frame(input string tag, input int n, input logic [31:0] payload);
    logic [7:0] b;
    int         addr;
    exp_t       e;
    cs_low();
    addr = 0;
    for (int k = 0; k < n; k++) begin
      b = 8'(payload >> (8 * (n - 1 - k)));
      if (k == 0) begin
        addr = int'(b);
      end else begin
        if ((BURST || k == 1) && is_writable(addr)) begin
          m_regs[addr] = b;
          e.addr = addr;
          e.val = b;
          exp_q.push_back(e);
        end
        addr = (addr + 1) % 256;
      end
      spi_bits(b, 8);
    end
    cs_high();
    drain(tag);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    m_status = 8'h00;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    compare_all("reset");

    // Control register
    send_frame("ctrl", 2, 32'h001D);
    check("ctrl_value", {24'h0, reg_control}, 32'h1D);

    // Frequency, one register per frame at 1 MHz SCK
    sck_half = 500;
    send_frame("freq_lo", 2, 32'h0200);
    send_frame("freq_mid", 2, 32'h0340);
    send_frame("freq_hi", 2, 32'h0402);
    check("freq_word", {8'h0, reg_freq_high, reg_freq_mid, reg_freq_low}, 32'h024000);
    sck_half = 80;

    // Duty and volume sweep
    send_frame("duty", 2, 32'h0540);
    check("duty_value", {24'h0, reg_duty}, 32'h40);
    send_frame("vol80", 2, 32'h0680);
    check("vol_80", {24'h0, reg_volume}, 32'h80);
    send_frame("vol00", 2, 32'h0600);
    check("vol_00", {24'h0, reg_volume}, 32'h00);
    send_frame("vol40", 2, 32'h0640);
    check("vol_40", {24'h0, reg_volume}, 32'h40);
    send_frame("volC0", 2, 32'h06C0);
    check("vol_C0", {24'h0, reg_volume}, 32'hC0);
    send_frame("volFF", 2, 32'h06FF);
    check("vol_FF", {24'h0, reg_volume}, 32'hFF);

    // Capture latency: data must land within 4 clk of the 8th SCK rising edge
    cs_low();
    spi_bits(8'h06, 8);
    spi_bits(8'h5A, 7);
    spi_mosi = 1'b0;
    #(sck_half);
    spi_sck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("latency_vol", {24'h0, reg_volume}, 32'h5A);
    m_regs[6] = 8'h5A;
    #(sck_half);
    spi_sck = 1'b0;
    cs_high();
    drain("latency");

    // Unmapped address
    send_frame("inval07", 2, 32'h0742);

    // Partial data byte aborted by CS
    cs_low();
    spi_bits(8'h05, 8);
    spi_bits(8'h77, 4);
    cs_high();
    drain("partial");
    check("partial_duty", {24'h0, reg_duty}, 32'h40);

    // Status path and write-protection of 0x12
    @(posedge clk);
    #2;
    status_gate_active = 1'b1;
    status_osc_running = 1'b1;
    m_status = 8'h03;
    repeat (3) @(posedge clk);
    #1;
    check("status_lat", {24'h0, reg_status}, 32'h03);
    send_frame("stat_wr", 2, 32'h12FF);
    check("status_ro", {24'h0, reg_status}, 32'h03);

    // Burst frame from reset
    pulse_reset();
    repeat (4) @(posedge clk);
    send_frame("burst", 4, 32'h02AABBCC);
    check("burst_freq", {8'h0, reg_freq_high, reg_freq_mid, reg_freq_low},
          BURST ? 32'hCCBBAA : 32'h0000AA);

    // Reset mid-frame; CS stays low afterwards so no new frame may start
    status_gate_active = 1'b0;
    status_osc_running = 1'b0;
    m_status = 8'h00;
    send_frame("pre_rst", 2, 32'h001D);
    cs_low();
    spi_bits(8'h00, 3);
    pulse_reset();
    spi_bits(8'h00, 8);
    spi_bits(8'h33, 8);
    cs_high();
    drain("midrst");
    check("midrst_ctrl", {24'h0, reg_control}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
